// File: rtl/grid_pixel_writer.sv
// Drives an 8080-style 8-bit LCD write bus from game-grid cell requests.
// Handles the power-up init stream with timed waits, then fills one CELL_PX x CELL_PX cell per request.
module grid_pixel_writer #(
  parameter int          GRID_BITS = 4,
  parameter int          CELL_PX   = 10,
  parameter int          HALF      = 1,
  parameter int          RST_DLY   = 1200,
  parameter int          SLP_DLY   = 12000,
  parameter logic [7:0]  MADCTL    = 8'h00
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 init_cycle,
  input  logic                 en_update,
  input  logic [GRID_BITS-1:0] x,
  input  logic [GRID_BITS-1:0] y,
  input  logic [2:0]           obj_code,
  output logic                 busy,
  output logic                 cmd_done,
  output logic                 inited,
  output logic                 wr,
  output logic                 dcx,
  output logic [7:0]           D
);

  // state     | meaning
  // IDLE      | bus quiet, sampling init_cycle / en_update
  // INIT_SEND | clocking out init command/data bytes
  // INIT_WAIT | timed pause after SWRESET or SLPOUT
  // ADDR      | column (2A) and page (2B) address windows
  // RAMWR     | memory write command (2C)
  // PIXELS    | colour bytes, high then low, for every pixel in the cell
  // DONE      | one-cycle completion pulse
  typedef enum logic [2:0] {IDLE, INIT_SEND, INIT_WAIT, ADDR, RAMWR, PIXELS, DONE} state_t;

  localparam int PHW     = $clog2(2*HALF);
  localparam int NPIX    = CELL_PX*CELL_PX;
  localparam int PCW     = $clog2(NPIX+1);
  localparam int DLY_MAX = (RST_DLY > SLP_DLY) ? RST_DLY : SLP_DLY;
  localparam int TW      = $clog2(DLY_MAX+1);

  localparam logic [PHW-1:0] PH_TOP  = PHW'(2*HALF-1);
  localparam logic [PHW-1:0] PH_HALF = PHW'(HALF);
  localparam logic [TW-1:0]  RST_LD  = TW'(RST_DLY-1);
  localparam logic [TW-1:0]  SLP_LD  = TW'(SLP_DLY-1);
  localparam logic [PCW-1:0] NPIX_LD = PCW'(NPIX);
  localparam logic [15:0]    CELL16  = 16'(CELL_PX);

  state_t               state;
  logic [PHW-1:0]       ph;
  logic [3:0]           idx;
  logic [TW-1:0]        tmr;
  logic [PCW-1:0]       pix_left;
  logic                 lo_sel;
  logic [GRID_BITS-1:0] x_q, y_q;
  logic [15:0]          col_q;
  logic [15:0]          x0, x1, y0, y1;
  logic                 addr_dcx;
  logic [7:0]           addr_d;

  function automatic logic [8:0] init_byte(input logic [3:0] i);
    case (i)
      4'd0:    return {1'b0, 8'h01};
      4'd1:    return {1'b0, 8'h11};
      4'd2:    return {1'b0, 8'h3A};
      4'd3:    return {1'b1, 8'h55};
      4'd4:    return {1'b0, 8'h36};
      4'd5:    return {1'b1, MADCTL};
      default: return {1'b0, 8'h29};
    endcase
  endfunction

  function automatic logic [15:0] palette(input logic [2:0] c);
    case (c)
      3'd0:    return 16'h0000;
      3'd1:    return 16'hFFFF;
      3'd2:    return 16'hF800;
      3'd3:    return 16'h07E0;
      3'd4:    return 16'h001F;
      3'd5:    return 16'hFFE0;
      3'd6:    return 16'h07FF;
      default: return 16'hF81F;
    endcase
  endfunction

  assign x0 = 16'(x_q) * CELL16;
  assign y0 = 16'(y_q) * CELL16;
  assign x1 = x0 + CELL16 - 16'd1;
  assign y1 = y0 + CELL16 - 16'd1;

  // idx names the next address-phase byte; 0 (2A) is sent on acceptance
  always_comb begin
    addr_dcx = 1'b1;
    addr_d   = 8'h00;
    case (idx)
      4'd1: addr_d = x0[15:8];
      4'd2: addr_d = x0[7:0];
      4'd3: addr_d = x1[15:8];
      4'd4: addr_d = x1[7:0];
      4'd5: begin addr_dcx = 1'b0; addr_d = 8'h2B; end
      4'd6: addr_d = y0[15:8];
      4'd7: addr_d = y0[7:0];
      4'd8: addr_d = y1[15:8];
      4'd9: addr_d = y1[7:0];
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state    <= IDLE;
      wr       <= 1'b1;
      dcx      <= 1'b1;
      D        <= 8'h00;
      busy     <= 1'b0;
      cmd_done <= 1'b0;
      inited   <= 1'b0;
      ph       <= '0;
      idx      <= '0;
      tmr      <= '0;
      pix_left <= '0;
      lo_sel   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      col_q    <= '0;
    end else begin
      // window tick; a byte launch below overrides wr/ph on the last cycle
      if (ph != '0) begin
        ph <= ph - 1'b1;
        wr <= (ph <= PH_HALF);
      end
      case (state)
        IDLE: begin
          if (init_cycle) begin
            {wr, dcx, D, ph} <= {1'b0, init_byte(4'd0), PH_TOP};
            idx   <= 4'd1;
            busy  <= 1'b1;
            state <= INIT_SEND;
          end else if (en_update && inited) begin
            {wr, dcx, D, ph} <= {1'b0, 1'b0, 8'h2A, PH_TOP};
            x_q   <= x;
            y_q   <= y;
            col_q <= palette(obj_code);
            idx   <= 4'd1;
            busy  <= 1'b1;
            state <= ADDR;
          end
        end
        INIT_SEND: begin
          if (ph == '0) begin
            if (idx == 4'd1 || idx == 4'd2) begin
              tmr   <= (idx == 4'd1) ? RST_LD : SLP_LD;
              state <= INIT_WAIT;
            end else if (idx == 4'd7) begin
              inited   <= 1'b1;
              cmd_done <= 1'b1;
              state    <= DONE;
            end else begin
              {wr, dcx, D, ph} <= {1'b0, init_byte(idx), PH_TOP};
              idx <= idx + 1'b1;
            end
          end
        end
        INIT_WAIT: begin
          if (tmr != '0) begin
            tmr <= tmr - 1'b1;
          end else begin
            {wr, dcx, D, ph} <= {1'b0, init_byte(idx), PH_TOP};
            idx   <= idx + 1'b1;
            state <= INIT_SEND;
          end
        end
        ADDR: begin
          if (ph == '0) begin
            if (idx == 4'd10) begin
              {wr, dcx, D, ph} <= {1'b0, 1'b0, 8'h2C, PH_TOP};
              state <= RAMWR;
            end else begin
              {wr, dcx, D, ph} <= {1'b0, addr_dcx, addr_d, PH_TOP};
              idx <= idx + 1'b1;
            end
          end
        end
        RAMWR: begin
          if (ph == '0) begin
            {wr, dcx, D, ph} <= {1'b0, 1'b1, col_q[15:8], PH_TOP};
            pix_left <= NPIX_LD;
            lo_sel   <= 1'b1;
            state    <= PIXELS;
          end
        end
        PIXELS: begin
          if (ph == '0) begin
            if (lo_sel) begin
              {wr, dcx, D, ph} <= {1'b0, 1'b1, col_q[7:0], PH_TOP};
              lo_sel <= 1'b0;
            end else if (pix_left == PCW'(1)) begin
              cmd_done <= 1'b1;
              state    <= DONE;
            end else begin
              {wr, dcx, D, ph} <= {1'b0, 1'b1, col_q[15:8], PH_TOP};
              pix_left <= pix_left - 1'b1;
              lo_sel   <= 1'b1;
            end
          end
        end
        DONE: begin
          cmd_done <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_grid_pixel_writer.sv
// Scoreboard bench for grid_pixel_writer: expected bus bytes are queued at stimulus time
// and popped on every wr rising edge; a second HALF=2 instance checks strobe timing.
module tb_grid_pixel_writer;

  logic       tb_clk = 1'b0;
  logic       nrst = 1'b0;
  logic       init_cycle = 1'b0, en_update = 1'b0;
  logic [3:0] x = '0, y = '0;
  logic [2:0] obj_code = '0;
  logic       busy, cmd_done, inited, wr, dcx;
  logic [7:0] D;

  logic       init2 = 1'b0, en2 = 1'b0;
  logic [1:0] x2 = '0, y2 = '0;
  logic [2:0] obj2 = '0;
  logic       busy2, done2, inited2, wr2, dcx2;
  logic [7:0] d2;

  int n_chk = 0, n_err = 0;
  int cyc = 0;
  int falls = 0, lo_run = 0;
  logic prev_wr = 1'b1;
  int fall_cyc[$];
  logic [8:0] sb_q[$];
  int bytes2 = 0, lo2 = 0;
  logic prev_wr2 = 1'b1;
  logic [8:0] last2 = '0;

  grid_pixel_writer #(.GRID_BITS(4), .CELL_PX(10), .HALF(1), .RST_DLY(1200),
                      .SLP_DLY(12000), .MADCTL(8'h00)) dut (
    .clk(tb_clk), .nrst(nrst), .init_cycle(init_cycle), .en_update(en_update),
    .x(x), .y(y), .obj_code(obj_code), .busy(busy), .cmd_done(cmd_done),
    .inited(inited), .wr(wr), .dcx(dcx), .D(D));

  grid_pixel_writer #(.GRID_BITS(2), .CELL_PX(2), .HALF(2), .RST_DLY(3),
                      .SLP_DLY(4), .MADCTL(8'h48)) dut2 (
    .clk(tb_clk), .nrst(nrst), .init_cycle(init2), .en_update(en2),
    .x(x2), .y(y2), .obj_code(obj2), .busy(busy2), .cmd_done(done2),
    .inited(inited2), .wr(wr2), .dcx(dcx2), .D(d2));

  always #5 tb_clk = ~tb_clk;
  always @(posedge tb_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] pal(input int c);
    case (c)
      0: return 16'h0000;  1: return 16'hFFFF;  2: return 16'hF800;  3: return 16'h07E0;
      4: return 16'h001F;  5: return 16'hFFE0;  6: return 16'h07FF;  default: return 16'hF81F;
    endcase
  endfunction

  task automatic push_byte(input logic c, input logic [7:0] b);
    sb_q.push_back({c, b});
  endtask

  task automatic push16(input int v);
    logic [15:0] w;
    w = 16'(v);
    push_byte(1'b1, w[15:8]);
    push_byte(1'b1, w[7:0]);
  endtask

  task automatic push_init();
    push_byte(1'b0, 8'h01); push_byte(1'b0, 8'h11); push_byte(1'b0, 8'h3A);
    push_byte(1'b1, 8'h55); push_byte(1'b0, 8'h36); push_byte(1'b1, 8'h00);
    push_byte(1'b0, 8'h29);
  endtask

  task automatic push_update(input int cx, input int cy, input int obj);
    logic [15:0] col;
    col = pal(obj);
    push_byte(1'b0, 8'h2A); push16(cx*10); push16(cx*10 + 9);
    push_byte(1'b0, 8'h2B); push16(cy*10); push16(cy*10 + 9);
    push_byte(1'b0, 8'h2C);
    for (int i = 0; i < 100; i++) begin
      push_byte(1'b1, col[15:8]);
      push_byte(1'b1, col[7:0]);
    end
  endtask

  // waits for the completion pulse, then confirms it lasts one cycle
  task automatic wait_done(input int limit, output int c);
    for (int i = 0; i < limit; i++) begin
      @(negedge tb_clk);
      if (cmd_done) break;
    end
    chk("done_seen", cmd_done, 1);
    c = cyc;
    @(negedge tb_clk);
    chk("done_pulse", cmd_done, 0);
    chk("busy_clr", busy, 0);
  endtask

  task automatic start_update(input int cx, input int cy, input int obj, output int acc);
    push_update(cx, cy, obj);
    x = 4'(cx); y = 4'(cy); obj_code = 3'(obj);
    en_update = 1'b1;
    acc = cyc;
    @(negedge tb_clk);
    en_update = 1'b0;
  endtask

  always @(negedge tb_clk) begin
    logic [8:0] e;
    if (prev_wr && !wr) begin
      falls++;
      fall_cyc.push_back(cyc);
    end
    if (nrst && !prev_wr && wr) begin
      chk("wr_low_len", lo_run, 1);
      if (sb_q.size() == 0) chk("byte_extra", sb_q.size(), 1);
      else begin
        e = sb_q.pop_front();
        chk("byte", {dcx, D}, e);
      end
    end
    if (wr) lo_run = 0; else lo_run++;
    prev_wr = wr;
  end

  always @(negedge tb_clk) begin
    if (!prev_wr2 && wr2) begin
      chk("wr2_low_len", lo2, 2);
      bytes2++;
      last2 = {dcx2, d2};
    end
    if (wr2) lo2 = 0; else lo2++;
    prev_wr2 = wr2;
  end

  initial begin
    int acc, c, f0;
    repeat (3) @(negedge tb_clk);
    chk("rst_wr", wr, 1);       chk("rst_dcx", dcx, 1);    chk("rst_D", D, 0);
    chk("rst_busy", busy, 0);   chk("rst_done", cmd_done, 0); chk("rst_inited", inited, 0);
    nrst = 1'b1;
    @(negedge tb_clk);

    // update before init: must be ignored
    f0 = falls;
    x = 4'd3; en_update = 1'b1;
    repeat (50) @(negedge tb_clk);
    chk("preinit_busy", busy, 0);
    chk("preinit_falls", falls - f0, 0);
    en_update = 1'b0;
    @(negedge tb_clk);

    // init sequence and its two timed gaps
    fall_cyc.delete();
    push_init();
    init_cycle = 1'b1;
    @(negedge tb_clk);
    init_cycle = 1'b0;
    chk("init_busy", busy, 1);
    wait_done(20000, c);
    chk("init_inited", inited, 1);
    chk("init_q_empty", sb_q.size(), 0);
    chk("init_falls", fall_cyc.size(), 7);
    if (fall_cyc.size() >= 3) begin
      chk("rst_gap", fall_cyc[1] - fall_cyc[0], 1202);
      chk("slp_gap", fall_cyc[2] - fall_cyc[1], 12002);
    end

    // nominal update and latency
    start_update(3, 2, 2, acc);
    wait_done(1000, c);
    chk("upd_latency", c - acc, 423);
    chk("upd_q_empty", sb_q.size(), 0);

    // edge cell, with ignored request and colour change mid-PIXELS
    start_update(15, 15, 7, acc);
    repeat (100) @(negedge tb_clk);
    chk("edge_busy", busy, 1);
    obj_code = 3'd1; en_update = 1'b1;
    @(negedge tb_clk);
    en_update = 1'b0;
    wait_done(1000, c);
    chk("edge_latency", c - acc, 423);
    f0 = falls;
    repeat (50) @(negedge tb_clk);
    chk("edge_no_second", falls - f0, 0);
    chk("edge_q_empty", sb_q.size(), 0);

    // init and update together: init wins, inited stays set
    push_init();
    init_cycle = 1'b1; en_update = 1'b1; obj_code = 3'd3;
    @(negedge tb_clk);
    init_cycle = 1'b0; en_update = 1'b0;
    repeat (100) @(negedge tb_clk);
    chk("rerun_inited", inited, 1);
    chk("rerun_busy", busy, 1);
    wait_done(20000, c);
    chk("rerun_q_empty", sb_q.size(), 0);

    // reset during PIXELS
    start_update(1, 1, 4, acc);
    repeat (60) @(negedge tb_clk);
    nrst = 1'b0;
    repeat (2) @(negedge tb_clk);
    nrst = 1'b1;
    sb_q.delete();
    chk("midrst_wr", wr, 1);     chk("midrst_dcx", dcx, 1);   chk("midrst_D", D, 0);
    chk("midrst_busy", busy, 0); chk("midrst_inited", inited, 0);
    f0 = falls;
    repeat (50) @(negedge tb_clk);
    chk("midrst_falls", falls - f0, 0);

    // HALF=2 instance: strobe shape, latency and final byte
    bytes2 = 0;
    init2 = 1'b1;
    @(negedge tb_clk);
    init2 = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge tb_clk);
      if (done2) break;
    end
    chk("h2_init_done", done2, 1);
    @(negedge tb_clk);
    chk("h2_inited", inited2, 1);
    chk("h2_init_bytes", bytes2, 7);
    x2 = 2'd3; y2 = 2'd3; obj2 = 3'd5; en2 = 1'b1;
    acc = cyc;
    @(negedge tb_clk);
    en2 = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge tb_clk);
      if (done2) break;
    end
    chk("h2_done", done2, 1);
    chk("h2_latency", cyc - acc, 77);
    chk("h2_bytes", bytes2, 26);
    chk("h2_last_byte", last2, 9'h1E0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/grid_pixel_writer.md
Name: grid_pixel_writer

Overview:
Parametrised successor to the single-cell pixel updater. It drives an 8080-style 8-bit LCD write bus (wr/dcx/D) from a game-grid request (x, y, obj_code). It runs a configurable power-up init sequence with timed delays, then fills one CELL_PX x CELL_PX cell per request with an RGB565 palette colour. The block sits between the game-logic FSM and the LCD pins.

Parameters:
GRID_BITS, 4, width of x and y; the grid is 2^GRID_BITS cells per side
CELL_PX, 10, side of one cell in pixels; (2^GRID_BITS)*CELL_PX must be <= 65536
HALF, 1, clock cycles per wr half-phase (>=1)
RST_DLY, 1200, idle cycles after SWRESET
SLP_DLY, 12000, idle cycles after SLPOUT
MADCTL, 8'h00, data byte sent with MADCTL (0x36)

Ports:
clk  in  1  system clock
nrst  in  1  synchronous active-low reset
init_cycle  in  1  start init sequence (level, sampled in IDLE)
en_update  in  1  start cell update (level, sampled in IDLE)
x  in  GRID_BITS  cell column
y  in  GRID_BITS  cell row
obj_code  in  3  palette index
busy  out  1  high in every non-IDLE state
cmd_done  out  1  one-cycle pulse when init or update completes
inited  out  1  init completed since reset
wr  out  1  LCD write strobe, active low
dcx  out  1  0 = command byte, 1 = data byte
D  out  8  LCD data bus

Behaviour:
- One clock, clk. Reset is synchronous and active-low on nrst. Reset values: wr=1, dcx=1, D=0, busy=0, cmd_done=0, inited=0; state returns to IDLE. Reset mid-transfer aborts the transfer immediately, with no partial-byte completion.
- Byte transfer: each byte takes a window of 2*HALF cycles. D and dcx are set on the first cycle and held for the whole window. wr=0 for the first HALF cycles and wr=1 for the last HALF cycles; the LCD latches on the rising edge of wr. Windows are back-to-back with no gap. Between transfers wr=1.
- States: IDLE, INIT_SEND, INIT_WAIT, ADDR, RAMWR, PIXELS, DONE.
- IDLE: init_cycle=1 -> INIT_SEND. init_cycle has priority over en_update.
- IDLE: en_update=1 and inited=1 -> latch x, y, obj_code, then -> ADDR. en_update with inited=0 is ignored and produces no bus activity.
- Inputs are ignored while busy; nothing is queued.
- Init stream (c=command, d=data): 01c, wait RST_DLY; 11c, wait SLP_DLY; 3Ac, 55d; 36c, MADCTL d; 29c. Waits are in INIT_WAIT with wr=1 and D held.
- After the last init byte: DONE for 1 cycle (cmd_done=1), inited<=1, -> IDLE.
- init_cycle while inited=1 reruns the full sequence; inited stays 1.
- ADDR: x0=x*CELL_PX, x1=x0+CELL_PX-1, same for y, all 16-bit unsigned. Send 2Ac, x0[15:8]d, x0[7:0]d, x1[15:8]d, x1[7:0]d, then 2Bc, followed by the same four data bytes for y0 and y1.
- RAMWR: send 2Cc.
- PIXELS: send CELL_PX*CELL_PX pixels, two data bytes each (colour[15:8] then colour[7:0]). The pixel counter is sized clog2(CELL_PX*CELL_PX+1).
- Palette: 0=0000, 1=FFFF, 2=F800, 3=07E0, 4=001F, 5=FFE0, 6=07FF, 7=F81F.
- Update length: 11+2*CELL_PX^2 bytes. cmd_done asserts in the cycle after the final wr-high phase. Total latency from acceptance to cmd_done = (11+2*CELL_PX^2)*2*HALF+1 cycles; 423 cycles at the defaults.
- Edge cell x=y=2^GRID_BITS-1: no overflow at the parameter limit.
- busy drops in the same cycle cmd_done pulses are cleared; the next request can be accepted the cycle after DONE.

Test Plan:
- Reset: hold nrst=0 for 2 cycles mid-PIXELS -> next cycle wr=1, dcx=1, D=0, busy=0, inited=0, and no further wr falls.
- Init: pulse init_cycle=1 -> bytes 01c, (1200 idle cycles), 11c, (12000 idle cycles), 3Ac, 55d, 36c, 00d, 29c; then one cmd_done pulse and inited=1.
- Pre-init update: en_update=1 with inited=0 -> wr stays 1 for 50 cycles and busy=0.
- Update x=3, y=2, obj=2 -> 2Ac 00 1E 00 27, 2Bc 00 14 00 1D, 2Cc, then 100 x (F8,00); cmd_done exactly 423 cycles after acceptance.
- Boundary x=15, y=15, obj=7 -> x0=y0=0096, x1=y1=009F, pixels F8,1F; HALF=2 build shows wr low 2 / high 2 cycles per byte.
- Busy ignore/priority: change obj_code and pulse en_update mid-PIXELS -> colour unchanged, no second transfer; init_cycle and en_update high together in IDLE -> init stream sent first.
